// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch input conditioning: button FSM encoding and
// default debounce timing.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StRel   = 2'd0,
    StPwait = 2'd1,
    StPress = 2'd2,
    StRwait = 2'd3
  } btn_state_e;

  // 10 ms at 100 MHz.
  localparam int unsigned DbCyclesDefault = 1_000_000;
  localparam int unsigned CntWDefault     = 20;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, press/release debounce FSM and a registered
// single-cycle pulse on each accepted press.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesDefault,
  parameter int unsigned CNT_W     = CntWDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] DbCnt = CNT_W'(DB_CYCLES);

  logic [1:0]       sync_q;
  logic             synced;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pulse_q, pulse_d;

  assign synced = sync_q[1];

  // The counter defaults to zero so every state change restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      StRel: begin
        if (synced) state_d = StPwait;
      end
      StPwait: begin
        if (!synced) begin
          state_d = StRel;
        end else if (cnt_inc == DbCnt) begin
          state_d = StPress;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPress: begin
        if (!synced) state_d = StRwait;
      end
      StRwait: begin
        if (synced) begin
          state_d = StPress;
        end else if (cnt_inc == DbCnt) begin
          state_d = StRel;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StRel;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= StRel;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign held_o  = (state_q == StPress) || (state_q == StRwait);

endmodule

// File: rtl/stopwatch_input_cond.sv
// Conditions the raw P/R buttons and sel/load switches for the stopwatch core:
// debounced button pulses with clear-wins arbitration and a debounced switch group.
module stopwatch_input_cond
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesDefault,
  parameter int unsigned CNT_W     = CntWDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_p,
  input  logic       btn_r,
  input  logic [1:0] sw_sel,
  input  logic [7:0] sw_load,
  output logic       p_pulse,
  output logic       r_pulse,
  output logic       r_held,
  output logic [1:0] sel_q,
  output logic [7:0] load_q,
  output logic       cfg_chg
);

  localparam logic [CNT_W-1:0] DbCnt = CNT_W'(DB_CYCLES);

  logic p_acc_pulse, r_acc_pulse, p_held_unused;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_btn_p (
    .clk_i  (clk),
    .rst_ni (reset),
    .btn_i  (btn_p),
    .pulse_o(p_acc_pulse),
    .held_o (p_held_unused)
  );

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_btn_r (
    .clk_i  (clk),
    .rst_ni (reset),
    .btn_i  (btn_r),
    .pulse_o(r_acc_pulse),
    .held_o (r_held)
  );

  // Clear wins: a P press accepted on the same cycle as R is dropped for good.
  assign p_pulse = p_acc_pulse & ~r_acc_pulse;
  assign r_pulse = r_acc_pulse;

  logic [9:0]       sw_s1_q, sw_s2_q, sw_last_q, cfg_q, cfg_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d, sw_cnt_inc;
  logic             chg_q, chg_d;

  // Counter saturates at DbCnt so a long-stable group is only evaluated once.
  always_comb begin
    sw_cnt_d   = sw_cnt_q;
    cfg_d      = cfg_q;
    chg_d      = 1'b0;
    sw_cnt_inc = sw_cnt_q + CNT_W'(1);
    if (sw_s2_q != sw_last_q) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q != DbCnt) begin
      sw_cnt_d = sw_cnt_inc;
      if ((sw_cnt_inc == DbCnt) && (sw_s2_q != cfg_q)) begin
        cfg_d = sw_s2_q;
        chg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_last_q <= '0;
      sw_cnt_q  <= '0;
      cfg_q     <= '0;
      chg_q     <= 1'b0;
    end else begin
      sw_s1_q   <= {sw_sel, sw_load};
      sw_s2_q   <= sw_s1_q;
      sw_last_q <= sw_s2_q;
      sw_cnt_q  <= sw_cnt_d;
      cfg_q     <= cfg_d;
      chg_q     <= chg_d;
    end
  end

  assign sel_q   = cfg_q[9:8];
  assign load_q  = cfg_q[7:0];
  assign cfg_chg = chg_q;

endmodule

// File: tb/tb_stopwatch_input_cond.sv
// Bench for stopwatch_input_cond: a per-cycle behavioural model plus directed
// scenarios with hand-computed counts and timings.
module tb_stopwatch_input_cond;

  localparam int unsigned DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_p = 1'b0;
  logic       btn_r = 1'b0;
  logic [1:0] sw_sel = 2'd0;
  logic [7:0] sw_load = 8'd0;
  logic       p_pulse, r_pulse, r_held, cfg_chg;
  logic [1:0] sel_q;
  logic [7:0] load_q;

  always #5 clk = ~clk;

  stopwatch_input_cond #(
    .DB_CYCLES(DB),
    .CNT_W    (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_p  (btn_p),
    .btn_r  (btn_r),
    .sw_sel (sw_sel),
    .sw_load(sw_load),
    .p_pulse(p_pulse),
    .r_pulse(r_pulse),
    .r_held (r_held),
    .sel_q  (sel_q),
    .load_q (load_q),
    .cfg_chg(cfg_chg)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a level is accepted once the synced input has differed from the
  // accepted level for DB+1 consecutive samples; the switch group is published
  // once its synced value has been unchanged for DB samples.
  bit [1:0] mp_d, mr_d;
  bit [9:0] msw_d1, msw_d2, msw_prev, m_cfg;
  bit       m_pa, m_ra, m_ppulse, m_rpulse, m_chg;
  int       m_prun, m_rrun, m_swrun;

  function automatic void btn_step(input bit s, inout bit acc, inout int run, output bit pulse);
    pulse = 1'b0;
    if (s != acc) begin
      run++;
      if (run == DB + 1) begin
        acc   = s;
        run   = 0;
        pulse = s;
      end
    end else begin
      run = 0;
    end
  endfunction

  initial begin
    bit pp, rp;
    bit [9:0] v;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mp_d = '0; mr_d = '0; msw_d1 = '0; msw_d2 = '0; msw_prev = '0; m_cfg = '0;
        m_pa = 0; m_ra = 0; m_ppulse = 0; m_rpulse = 0; m_chg = 0;
        m_prun = 0; m_rrun = 0; m_swrun = 0;
      end else begin
        btn_step(mp_d[1], m_pa, m_prun, pp);
        btn_step(mr_d[1], m_ra, m_rrun, rp);
        mp_d = {mp_d[0], btn_p};
        mr_d = {mr_d[0], btn_r};
        m_ppulse = pp && !rp;
        m_rpulse = rp;
        v = msw_d2;
        msw_d2 = msw_d1;
        msw_d1 = {sw_sel, sw_load};
        if (v == msw_prev) m_swrun++;
        else m_swrun = 0;
        msw_prev = v;
        m_chg = 1'b0;
        if (m_swrun == DB && v != m_cfg) begin
          m_cfg = v;
          m_chg = 1'b1;
        end
      end
    end
  end

  // Observed-event bookkeeping used by the directed checks.
  int p_cnt, r_cnt, cfg_cnt, p_cyc, r_cyc, cfg_cyc, r_fall, bad_load;
  logic r_held_prev = 1'b0;

  initial begin
    logic [13:0] got, want;
    forever begin
      @(negedge clk);
      got  = {p_pulse, r_pulse, r_held, sel_q, load_q, cfg_chg};
      want = {m_ppulse, m_rpulse, m_ra, m_cfg[9:8], m_cfg[7:0], m_chg};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL model cyc=%0d got p,r,held,sel,load,chg=%b,%b,%b,%h,%h,%b want %b,%b,%b,%h,%h,%b",
                 cyc, got[13], got[12], got[11], got[10:9], got[8:1], got[0],
                 want[13], want[12], want[11], want[10:9], want[8:1], want[0]);
      end
      if (p_pulse) begin p_cnt++; p_cyc = cyc; end
      if (r_pulse) begin r_cnt++; r_cyc = cyc; end
      if (cfg_chg) begin cfg_cnt++; cfg_cyc = cyc; end
      if (r_held_prev && !r_held) r_fall = cyc;
      if (load_q != 8'h00 && load_q != 8'h5A) bad_load++;
      r_held_prev = r_held;
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    p_cnt = 0; r_cnt = 0; cfg_cnt = 0; p_cyc = -1; r_cyc = -1; cfg_cyc = -1;
    r_fall = -1; bad_load = 0;
  endtask

  initial begin
    int c0;
    clr();
    // 1: reset with P held and all switches high.
    #1 reset = 1'b0;
    btn_p = 1'b1; sw_sel = 2'd3; sw_load = 8'hFF;
    tick(3);
    check("reset_state", int'({p_pulse, r_pulse, r_held, sel_q, load_q, cfg_chg}), 0);
    clr();
    reset = 1'b1;
    c0 = cyc;
    tick(15);
    check("t1_p_cnt", p_cnt, 1);
    check("t1_p_cyc", p_cyc, c0 + 11);
    check("t1_cfg_cnt", cfg_cnt, 1);
    check("t1_cfg_cyc", cfg_cyc, c0 + 11);
    check("t1_sel", int'(sel_q), 3);
    check("t1_load", int'(load_q), 255);
    btn_p = 1'b0;
    tick(20);

    // 2: bouncing P press.
    clr();
    btn_p = 1'b1; tick(3);
    btn_p = 1'b0; tick(3);
    btn_p = 1'b1; tick(3);
    btn_p = 1'b0; tick(3);
    btn_p = 1'b1;
    c0 = cyc;
    tick(20);
    check("t2_p_cnt", p_cnt, 1);
    check_rng("t2_p_cyc", p_cyc, c0 + 10, c0 + 12);
    btn_p = 1'b0;
    tick(20);

    // 3: R held for 50 cycles.
    clr();
    btn_r = 1'b1;
    c0 = cyc;
    tick(50);
    check("t3_r_cnt", r_cnt, 1);
    check("t3_r_cyc", r_cyc, c0 + 11);
    check("t3_r_held", int'(r_held), 1);
    btn_r = 1'b0;
    c0 = cyc;
    tick(20);
    check("t3_r_fall", r_fall, c0 + 11);
    check("t3_p_cnt", p_cnt, 0);

    // 4: simultaneous P and R.
    clr();
    btn_p = 1'b1; btn_r = 1'b1;
    tick(30);
    check("t4_r_cnt", r_cnt, 1);
    btn_p = 1'b0; btn_r = 1'b0;
    tick(20);
    check("t4_p_cnt", p_cnt, 0);

    // 5: load switch with a glitch.
    sw_sel = 2'd0; sw_load = 8'h00;
    tick(20);
    clr();
    sw_load = 8'h5A; tick(4);
    sw_load = 8'h00; tick(4);
    sw_load = 8'h5A;
    c0 = cyc;
    tick(20);
    check("t5_cfg_cnt", cfg_cnt, 1);
    check("t5_cfg_cyc", cfg_cyc, c0 + 11);
    check("t5_load", int'(load_q), 90);
    check("t5_bad_load", bad_load, 0);

    // 6: reset in the middle of a P debounce.
    clr();
    btn_p = 1'b1;
    tick(8);
    reset = 1'b0;
    #1;
    check("t6_rst_async", int'({p_pulse, r_pulse, r_held, sel_q, load_q, cfg_chg}), 0);
    tick(3);
    check("t6_p_during_rst", p_cnt, 0);
    clr();
    reset = 1'b1;
    c0 = cyc;
    tick(15);
    check("t6_p_cnt", p_cnt, 1);
    check("t6_p_cyc", p_cyc, c0 + 11);
    check("t6_load", int'(load_q), 90);
    btn_p = 1'b0;
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
